mac_block_accumulator: RTL and testbench
========================================

Name: mac_block_accumulator

Overview:
- Downstream stage of the 8-bit multiply-add register (A*B+C, registered DATA_OUT).
- Consumes its result stream one sample per accepted cycle and sums fixed-size blocks of N_SAMPLES results.
- Tracks the block maximum and presents sum and max through a one-deep valid/ready output register.
- Accumulation continues while a finished block waits for the consumer.

Parameters:
- DATA_W, 8, width of incoming samples; must match the multiply-add stage output.
- N_SAMPLES, 4, samples per block; legal range 2..256, not required to be a power of two.
- SUM_W, DATA_W+$clog2(N_SAMPLES), derived localparam, not overridable; the sum cannot overflow.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of the block in progress.
- in_valid  in  1  in_data holds a sample.
- in_data  in  DATA_W  sample from the multiply-add stage's DATA_OUT.
- in_ready  out  1  block can accept a sample this cycle.
- out_valid  out  1  out_sum and out_max hold a completed block.
- out_sum  out  SUM_W  sum of the N_SAMPLES samples in the block, unsigned.
- out_max  out  DATA_W  largest sample in the block.
- out_ready  in  1  consumer accepts the output this cycle.

Behaviour:
- Reset (async assert, sync deassert handled at top level):
  - acc=0, cnt=0, cur_max=0.
  - out_valid=0, out_sum=0, out_max=0, output state EMPTY.
  - in_ready=1 on the first cycle after deassertion.
- Accept condition: accept = in_valid & in_ready.
- Ready rule:
  - in_ready = !clr & !(stall).
  - stall = (state==FULL) & !out_ready & (cnt==N_SAMPLES-1).
  - Only the completing sample is stalled; samples 1..N-1 of the next block are accepted while FULL.
  - in_ready is combinational from state, cnt, clr and out_ready, with no path from in_valid.
- Accept of a non-final sample (cnt<N-1):
  - acc<=acc+in_data (zero-extended to SUM_W).
  - cur_max<=max(cur_max,in_data).
  - cnt<=cnt+1.
- Accept of the final sample (cnt==N-1):
  - out_sum<=acc+in_data.
  - out_max<=max(cur_max,in_data).
  - out_valid<=1, state FULL.
  - acc, cnt and cur_max reset to 0.
  - Latency: out_valid rises on the edge after the final sample is accepted (1 cycle).
- Output FSM (2 states, EMPTY and FULL):
  - EMPTY -> FULL on completion.
  - FULL -> EMPTY on out_ready with no completion in the same cycle.
  - FULL stays FULL on out_ready with a simultaneous completion: the new block is loaded and out_valid stays 1 with no bubble.
  - While FULL and !out_ready, out_sum and out_max hold stable.
- clr:
  - Sets acc, cnt and cur_max to 0 and forces in_ready=0, so no sample is accepted that cycle.
  - Does not touch out_valid, out_sum, out_max or the output state.
- Reset mid-block or mid-hold: all partial and pending data is discarded and the block returns to the reset values.
- in_data with in_valid=0 is ignored, including X.

Decomposition:
- Package mac_pkg:
  - DATA_W default constant, shared with the multiply-add stage.
  - typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t.
  - Function max_u(a,b).
- No sub-module. Single flat module with one always_ff (async reset) and one always_comb for in_ready and the next-state logic.

Test Plan (N_SAMPLES=4, out_ready=1 unless stated):
- Basic block: samples 10,20,30,40 on consecutive cycles -> one cycle after 40: out_valid=1, out_sum=100, out_max=40; next cycle out_valid=0.
- Width and saturation check: 255,255,255,255 -> out_sum=1020 (10-bit), out_max=255, no wrap.
- Backpressure: out_ready=0, first block 1,2,3,4 -> sum 10 held. Second block 5,6,7 accepted, 8 presented -> in_ready=0 and 8 is held. Raise out_ready -> sum 10 consumed, 8 accepted; next cycle out_sum=26, out_max=8.
- Simultaneous accept and complete: out_valid=1 with sum 10, and out_ready=1 in the cycle the 4th sample of the next block (block 5,6,7,8) is accepted -> next cycle out_valid stays 1 with out_sum=26, no gap.
- clr mid-block: accept 50,60, pulse clr together with in_valid (sample 70) -> in_ready=0 and 70 is dropped. Then 1,1,1,1 -> out_sum=4, out_max=1.
- Reset mid-hold: out_valid=1, out_ready=0, partial cnt=2, assert rst_n=0 asynchronously -> out_valid=0, out_sum=0, out_max=0 immediately. After release, 9,9,9,9 -> out_sum=36.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-add result path.
// - MAC_DATA_W  : sample width produced by the 8-bit multiply-add stage.
// - out_state_t : occupancy of the one-deep block-result output register.
// - max_u       : unsigned maximum of two values up to 32 bits wide.
package mac_pkg;

  localparam int unsigned MAC_DATA_W = 8;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;

  function automatic logic [31:0] max_u(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mac_block_accumulator.sv
// Block accumulator behind the multiply-add stage: sums blocks of N_SAMPLES
// unsigned samples, tracks the block maximum and presents both through a
// one-deep valid/ready output register. The next block keeps accumulating
// while a finished block waits; only its completing sample is stalled.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clr                synchronous clear of the block in progress
//   in_valid/in_ready  sample handshake, in_data is the sample
//   out_valid/out_ready result handshake, out_sum/out_max are the result
module mac_block_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W    = MAC_DATA_W,
  parameter int unsigned N_SAMPLES = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clr,
  input  logic                                  in_valid,
  input  logic [DATA_W-1:0]                     in_data,
  output logic                                  in_ready,
  output logic                                  out_valid,
  output logic [DATA_W+$clog2(N_SAMPLES)-1:0]   out_sum,
  output logic [DATA_W-1:0]                     out_max,
  input  logic                                  out_ready
);

  // Widest sum is N_SAMPLES * (2^DATA_W - 1), which always fits here.
  localparam int unsigned SUM_W = DATA_W + $clog2(N_SAMPLES);
  localparam int unsigned CNT_W = $clog2(N_SAMPLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

  out_state_t        state_q, state_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] cur_max_q, cur_max_d;
  logic [SUM_W-1:0]  out_sum_q, out_sum_d;
  logic [DATA_W-1:0] out_max_q, out_max_d;

  logic              last;
  logic              stall;
  logic              accept;
  logic [SUM_W-1:0]  new_sum;
  logic [DATA_W-1:0] new_max;

  always_comb begin
    last  = (cnt_q == LAST_CNT);
    // Only the completing sample must wait for the output register to drain.
    stall = (state_q == OUT_FULL) && !out_ready && last;
    in_ready = !clr && !stall;
    accept   = in_valid && in_ready;

    new_sum = acc_q + SUM_W'(in_data);
    new_max = DATA_W'(max_u(32'(cur_max_q), 32'(in_data)));

    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    cur_max_d = cur_max_q;
    out_sum_d = out_sum_q;
    out_max_d = out_max_q;

    // A consumed result empties the register unless a new block lands now.
    if (state_q == OUT_FULL && out_ready) begin
      state_d = OUT_EMPTY;
    end

    if (clr) begin
      acc_d     = '0;
      cnt_d     = '0;
      cur_max_d = '0;
    end else if (accept) begin
      if (last) begin
        out_sum_d = new_sum;
        out_max_d = new_max;
        state_d   = OUT_FULL;
        acc_d     = '0;
        cnt_d     = '0;
        cur_max_d = '0;
      end else begin
        acc_d     = new_sum;
        cnt_d     = cnt_q + CNT_W'(1);
        cur_max_d = new_max;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OUT_EMPTY;
      acc_q     <= '0;
      cnt_q     <= '0;
      cur_max_q <= '0;
      out_sum_q <= '0;
      out_max_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      cur_max_q <= cur_max_d;
      out_sum_q <= out_sum_d;
      out_max_q <= out_max_d;
    end
  end

  assign out_valid = (state_q == OUT_FULL);
  assign out_sum   = out_sum_q;
  assign out_max   = out_max_q;

endmodule

// File: tb/tb_mac_block_accumulator.sv
module tb_mac_block_accumulator;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [SW-1:0] out_sum;
  logic [DW-1:0] out_max;
  logic          out_ready = 1'b1;

  mac_block_accumulator #(
    .DATA_W   (DW),
    .N_SAMPLES(N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_sum  (out_sum),
    .out_max  (out_max),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: the samples of the block in progress and the result
  // register contents as seen by the consumer.
  int blk[$];
  bit exp_valid = 1'b0;
  int exp_sum   = 0;
  int exp_max   = 0;
  bit obs_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    blk.delete();
    exp_valid = 1'b0;
    exp_sum   = 0;
    exp_max   = 0;
  endtask

  // One clock cycle of stimulus; called right after a rising edge (+1).
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit ordy, input bit c);
    bit exp_rdy;
    bit done;
    int s;
    int m;
    in_valid  = v;
    in_data   = v ? d : DW'($urandom);
    out_ready = ordy;
    clr       = c;
    @(negedge clk);
    exp_rdy   = !c && !(exp_valid && !ordy && blk.size() == N - 1);
    obs_ready = in_ready;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    done = 1'b0;
    if (c) begin
      blk.delete();
    end else if (v && exp_rdy) begin
      blk.push_back(int'(d));
      if (blk.size() == N) begin
        s = 0;
        m = 0;
        foreach (blk[i]) begin
          s += blk[i];
          if (blk[i] > m) m = blk[i];
        end
        exp_sum = s;
        exp_max = m;
        done    = 1'b1;
        blk.delete();
      end
    end
    if (done) exp_valid = 1'b1;
    else if (exp_valid && ordy) exp_valid = 1'b0;
    #1;
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("out_sum", 32'(out_sum), 32'(exp_sum));
      check("out_max", 32'(out_max), 32'(exp_max));
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_max", 32'(out_max), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic block
    cycle(1, 8'd10, 1, 0);
    cycle(1, 8'd20, 1, 0);
    cycle(1, 8'd30, 1, 0);
    cycle(1, 8'd40, 1, 0);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_sum", 32'(out_sum), 32'd100);
    check("basic_max", 32'(out_max), 32'd40);
    cycle(0, 8'd0, 1, 0);
    check("basic_drop", 32'(out_valid), 32'd0);

    // Full-scale samples must not wrap
    repeat (4) cycle(1, 8'd255, 1, 0);
    check("wide_sum", 32'(out_sum), 32'd1020);
    check("wide_max", 32'(out_max), 32'd255);
    cycle(0, 8'd0, 1, 0);

    // Backpressure: only the completing sample stalls
    for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 0);
    check("bp_sum_held", 32'(out_sum), 32'd10);
    for (int i = 5; i <= 7; i++) cycle(1, 8'(i), 0, 0);
    cycle(1, 8'd8, 0, 0);
    check("bp_stall", 32'(obs_ready), 32'd0);
    check("bp_sum_stable", 32'(out_sum), 32'd10);
    cycle(1, 8'd8, 1, 0);
    check("bp_release", 32'(obs_ready), 32'd1);
    check("bp_sum2", 32'(out_sum), 32'd26);
    check("bp_max2", 32'(out_max), 32'd8);
    cycle(0, 8'd0, 1, 0);

    // Consume and complete in the same cycle: no bubble
    for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 1, 0);
    for (int i = 5; i <= 7; i++) cycle(1, 8'(i), 0, 0);
    check("nb_hold_sum", 32'(out_sum), 32'd10);
    cycle(1, 8'd8, 1, 0);
    check("nb_valid", 32'(out_valid), 32'd1);
    check("nb_sum", 32'(out_sum), 32'd26);
    cycle(0, 8'd0, 1, 0);

    // clr mid-block drops the concurrent sample
    cycle(1, 8'd50, 1, 0);
    cycle(1, 8'd60, 1, 0);
    cycle(1, 8'd70, 1, 1);
    check("clr_ready", 32'(obs_ready), 32'd0);
    repeat (4) cycle(1, 8'd1, 1, 0);
    check("clr_sum", 32'(out_sum), 32'd4);
    check("clr_max", 32'(out_max), 32'd1);
    cycle(0, 8'd0, 1, 0);

    // Asynchronous reset while holding a result and a partial block
    for (int i = 1; i <= 6; i++) cycle(1, 8'(i), 0, 0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_sum", 32'(out_sum), 32'd0);
    check("arst_max", 32'(out_max), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) cycle(1, 8'd9, 1, 0);
    check("arst_new_sum", 32'(out_sum), 32'd36);
    cycle(0, 8'd0, 1, 0);

    // Randomised traffic against the model
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom % 10) < 7, DW'($urandom), ($urandom % 10) < 6, ($urandom % 20) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
